// File: rtl/tcbm_pkg.sv
// ----------------------------------------------------------------------------
// tcbm_pkg
// Shared definitions for the host-side TCBM initiator:
//   - request op encodings and the TCBM command code bytes
//   - FSM state enum and the debug view struct exported by tcbm_host_xfer
//   - status value reported on a timed-out transaction
//   - small helpers mapping an op to its code byte / direction
// ----------------------------------------------------------------------------
package tcbm_pkg;

   typedef enum logic [1:0] {
      OP_SEND_CMD  = 2'd0,
      OP_SEND_DATA = 2'd1,
      OP_RECV_DATA = 2'd2,
      OP_RECV_STAT = 2'd3
   } tcbm_op_e;

   localparam logic [7:0] TCBM_CMD  = 8'h81;
   localparam logic [7:0] TCBM_DOUT = 8'h82;
   localparam logic [7:0] TCBM_DIN  = 8'h83;
   localparam logic [7:0] TCBM_STAT = 8'h84;

   // Reported in rsp_status when a transaction is aborted by timeout.
   localparam logic [1:0] TCBM_TO_STATUS = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      C_SETUP  = 3'd1,
      C_WAITHI = 3'd2,
      C_WAITLO = 3'd3,
      D_SETUP  = 3'd4,
      D_WAITHI = 3'd5,
      D_WAITLO = 3'd6,
      DONE     = 3'd7
   } tcbm_state_e;

   // Debug view: current FSM state and whether the DUT drives port_a.
   typedef struct packed {
      tcbm_state_e state;
      logic        port_oe;
   } tcbm_dbg_t;

   function automatic logic [7:0] op_code(input tcbm_op_e op);
      logic [7:0] code;
      case (op)
         OP_SEND_CMD:  code = TCBM_CMD;
         OP_SEND_DATA: code = TCBM_DOUT;
         OP_RECV_DATA: code = TCBM_DIN;
         default:      code = TCBM_STAT;
      endcase
      return code;
   endfunction

   // Ops 2 and 3 read the payload byte from the device.
   function automatic logic op_is_recv(input tcbm_op_e op);
      return op[1];
   endfunction

   function automatic logic is_wait(input tcbm_state_e st);
      return (st == C_WAITHI) || (st == C_WAITLO) ||
             (st == D_WAITHI) || (st == D_WAITLO);
   endfunction

endpackage

// File: rtl/tcbm_host_xfer_if.sv
// ----------------------------------------------------------------------------
// tcbm_host_xfer_if
// Host CPU side request/response bundle of the TCBM initiator.
//   req_valid/req_op/req_data/req_ready : request channel
//   rsp_valid/rsp_data/rsp_status/rsp_timeout : completion channel
//
// Handshake: a request is transferred on a rising clock edge where
// req_valid && req_ready. req_ready is high only while the initiator is
// idle; requests seen while req_ready is low are ignored (nothing is
// queued). rsp_valid is a one-clock pulse with no back-pressure; the
// rsp_data/rsp_status/rsp_timeout values hold until the next completion.
// ----------------------------------------------------------------------------
interface tcbm_host_xfer_if;
   logic       req_valid;
   logic [1:0] req_op;
   logic [7:0] req_data;
   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic [1:0] rsp_status;
   logic       rsp_timeout;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, rsp_valid, rsp_data, rsp_status, rsp_timeout
   );
endinterface

// File: rtl/tcbm_sync2.sv
// ----------------------------------------------------------------------------
// tcbm_sync2
// Two-flop synchronizer for the device-driven {ack, status} lines.
//   clock  : system clock
//   _reset : asynchronous active-low reset, clears both stages
//   d      : asynchronous inputs
//   q      : synchronized outputs (two clocks of latency)
// ----------------------------------------------------------------------------
module tcbm_sync2 #(
   parameter int unsigned W = 3
) (
   input  logic         clock,
   input  logic         _reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/tcbm_host_xfer.sv
// ----------------------------------------------------------------------------
// tcbm_host_xfer
// Host-side TCBM initiator. One accepted request becomes a two-byte TCBM
// transaction: a command code byte (0x81 + op) followed by a payload byte
// that is either sent (ops 0/1) or received (ops 2/3). Each byte uses the
// DAV (host->device) / ACK (device->host) four-phase handshake.
//
// Ports:
//   clock, _reset : system clock, asynchronous active-low reset
//   host          : tcbm_host_xfer_if.slave request/response channel
//   port_a        : 8-bit bidirectional TCBM data bus
//   status        : 2-bit device status lines (asynchronous)
//   dav           : data valid to device, active-high
//   ack           : acknowledge from device, active-high (asynchronous)
//   dbg           : FSM state and port_a output-enable, for observation
//
// Build option:
//   TCBM_TIMEOUT_EN : when defined, every ACK-wait state aborts after
//   TIMEOUT_CYCLES clocks (dav low, bus released, rsp_timeout=1,
//   rsp_status=2'b11, rsp_data=0). Undefined: waits are unbounded and
//   rsp_timeout is tied low.
// ----------------------------------------------------------------------------
module tcbm_host_xfer
   import tcbm_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned CNT_W          = 16
) (
   input  logic               clock,
   input  logic               _reset,
   tcbm_host_xfer_if.slave    host,
   inout  wire  [7:0]         port_a,
   input  logic [1:0]         status,
   output logic               dav,
   input  logic               ack,
   output tcbm_dbg_t          dbg
);

   // Elaboration-time sanity check of the counter sizing.
   if ((SETUP_CYCLES < 1) ||
       (64'(SETUP_CYCLES) >= (64'd1 << CNT_W)) ||
       (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W))) begin : g_cfg_check
      $error("tcbm_host_xfer: SETUP_CYCLES/TIMEOUT_CYCLES do not fit CNT_W");
   end

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Synchronized device lines
   // ---------------------------------------------------------------------
   logic       acks;
   logic [1:0] status_s;

   tcbm_sync2 #(.W(3)) u_sync (
      .clock  (clock),
      ._reset (_reset),
      .d      ({ack, status}),
      .q      ({acks, status_s})
   );

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   tcbm_state_e      state;
   tcbm_op_e         op_q;
   logic [7:0]       data_q;
   logic [CNT_W-1:0] cnt;
   logic             port_oe;
   logic [7:0]       port_out;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic [7:0]       rsp_data_q;
   logic [1:0]       rsp_status_q;
   logic             to_hit;

   assign port_a = port_oe ? port_out : 8'hzz;

   assign host.req_ready  = req_ready_q;
   assign host.rsp_valid  = rsp_valid_q;
   assign host.rsp_data   = rsp_data_q;
   assign host.rsp_status = rsp_status_q;

   assign dbg.state   = state;
   assign dbg.port_oe = port_oe;

`ifdef TCBM_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic rsp_timeout_q;

   // cnt is cleared on entry to each wait state, so it equals the number
   // of clocks already spent waiting.
   assign to_hit           = is_wait(state) && (cnt == TO_LAST);
   assign host.rsp_timeout = rsp_timeout_q;
`else
   assign to_hit           = 1'b0;
   assign host.rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state        <= IDLE;
         op_q         <= OP_SEND_CMD;
         data_q       <= '0;
         cnt          <= '0;
         port_oe      <= 1'b0;
         port_out     <= '0;
         dav          <= 1'b0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
`ifdef TCBM_TIMEOUT_EN
         rsp_timeout_q <= 1'b0;
`endif
      end else if (to_hit) begin
         // Abort: drop the handshake, free the bus and report it.
         dav          <= 1'b0;
         port_oe      <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= TCBM_TO_STATUS;
         rsp_valid_q  <= 1'b1;
         state        <= DONE;
`ifdef TCBM_TIMEOUT_EN
         rsp_timeout_q <= 1'b1;
`endif
      end else begin
`ifdef TCBM_TIMEOUT_EN
         // Exits below reassign cnt, which takes precedence.
         if (is_wait(state)) cnt <= cnt + 1'b1;
`endif
         case (state)
            IDLE: begin
               if (host.req_valid && req_ready_q) begin
                  op_q        <= tcbm_op_e'(host.req_op);
                  data_q      <= host.req_data;
                  port_out    <= op_code(tcbm_op_e'(host.req_op));
                  port_oe     <= 1'b1;
                  cnt         <= '0;
                  req_ready_q <= 1'b0;
`ifdef TCBM_TIMEOUT_EN
                  rsp_timeout_q <= 1'b0;
`endif
                  state       <= C_SETUP;
               end
            end

            C_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  dav   <= 1'b1;
                  cnt   <= '0;
                  state <= C_WAITHI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // A stale ACK (already high here) is taken at face value.
            C_WAITHI: begin
               if (acks) begin
                  dav   <= 1'b0;
                  cnt   <= '0;
                  state <= C_WAITLO;
               end
            end

            C_WAITLO: begin
               if (!acks) begin
                  cnt   <= '0;
                  state <= D_SETUP;
                  if (op_is_recv(op_q)) begin
                     port_oe <= 1'b0;
                  end else begin
                     port_out <= data_q;
                  end
               end
            end

            D_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  dav   <= 1'b1;
                  cnt   <= '0;
                  state <= D_WAITHI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // The device holds port_a stable before raising ACK, and the
            // synchronized ACK lags it by two clocks, so port_a is sampled
            // directly here.
            D_WAITHI: begin
               if (acks) begin
                  dav          <= 1'b0;
                  cnt          <= '0;
                  rsp_status_q <= status_s;
                  rsp_data_q   <= op_is_recv(op_q) ? port_a : 8'h00;
                  state        <= D_WAITLO;
               end
            end

            D_WAITLO: begin
               if (!acks) begin
                  port_oe     <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end

            DONE: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state       <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tcbm_host_xfer.sv
// ----------------------------------------------------------------------------
// tb_tcbm_host_xfer
// Bench for tcbm_host_xfer: a clocked device responder on the TCBM side,
// a bus monitor comparing each byte presented at a DAV rise, and a response
// scoreboard fed from the request driver.
// ----------------------------------------------------------------------------
module tb_tcbm_host_xfer;
   import tcbm_pkg::*;

   localparam int unsigned SETUP  = 4;
   localparam int unsigned TO_CYC = 50;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clock  = 1'b0;
   logic _reset = 1'b0;
   always #5 clock = ~clock;

   // ---------------------------------------------------------------------
   // DUT
   // ---------------------------------------------------------------------
   tcbm_host_xfer_if host ();
   wire  [7:0] port_a;
   logic [1:0] status;
   logic       dav;
   logic       ack;
   tcbm_dbg_t  dbg;
   logic       tb_drive;
   logic [7:0] tb_val;

   assign port_a = tb_drive ? tb_val : 8'hzz;

   tcbm_host_xfer #(
      .SETUP_CYCLES   (SETUP),
      .TIMEOUT_CYCLES (TO_CYC),
      .CNT_W          (16)
   ) dut (
      .clock  (clock),
      ._reset (_reset),
      .host   (host),
      .port_a (port_a),
      .status (status),
      .dav    (dav),
      .ack    (ack),
      .dbg    (dbg)
   );

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected responses {timeout, status, data} and bus bytes {oe, byte}.
   logic [10:0] exp_q[$];
   logic [8:0]  exp_bus_q[$];

   // Responder configuration
   int         ack_delay   = 3;
   int         ack_hold    = 1;
   logic       resp_silent = 1'b0;
   logic [7:0] resp_data   = 8'h00;

   // ---------------------------------------------------------------------
   // Device responder
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_HIGH} resp_st_e;
   resp_st_e   r_st;
   int         r_cnt;
   logic       r_data_phase;
   logic [1:0] r_op;

   always @(negedge clock or negedge _reset) begin
      if (!_reset) begin
         r_st         <= R_IDLE;
         r_cnt        <= 0;
         r_data_phase <= 1'b0;
         r_op         <= 2'd0;
         ack          <= 1'b0;
         tb_drive     <= 1'b0;
         tb_val       <= 8'h00;
      end else begin
         case (r_st)
            R_IDLE: if (dav && !resp_silent) begin
               if (!r_data_phase) r_op <= 2'(port_a - 8'h81);
               else if (r_op[1]) begin
                  tb_drive <= 1'b1;
                  tb_val   <= resp_data;
               end
               r_cnt <= 0;
               r_st  <= R_DELAY;
            end
            R_DELAY: if (r_cnt + 1 >= ack_delay) begin
               ack   <= 1'b1;
               r_cnt <= 0;
               r_st  <= R_HIGH;
            end else begin
               r_cnt <= r_cnt + 1;
            end
            R_HIGH: if (!dav && (r_cnt + 1 >= ack_hold)) begin
               ack          <= 1'b0;
               tb_drive     <= 1'b0;
               r_data_phase <= !r_data_phase;
               r_st         <= R_IDLE;
            end else begin
               r_cnt <= r_cnt + 1;
            end
            default: r_st <= R_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Bus monitor
   // ---------------------------------------------------------------------
   logic       prev_dav, prev_oe;
   logic [7:0] prev_pa;
   int         stable_cnt;
   int         dav_hi_len;
   int         last_dav_len = 0;
   int         viol_dav_ack = 0;
   int         viol_rsp_ack = 0;

   always @(negedge clock) begin
      if (!_reset) begin
         prev_dav   <= 1'b0;
         prev_oe    <= 1'b0;
         prev_pa    <= 8'h00;
         stable_cnt <= 0;
         dav_hi_len <= 0;
      end else begin
         prev_dav <= dav;
         prev_oe  <= dbg.port_oe;
         prev_pa  <= port_a;
         if (dbg.port_oe && prev_oe && (port_a == prev_pa)) stable_cnt <= stable_cnt + 1;
         else stable_cnt <= dbg.port_oe ? 1 : 0;
         if (dav && !prev_dav) begin
            check_eq("bus_expected", 32'(exp_bus_q.size() > 0), 1);
            if (exp_bus_q.size() > 0) begin
               check_eq("bus_byte", {23'd0, dbg.port_oe, (dbg.port_oe ? port_a : 8'h00)},
                        {23'd0, exp_bus_q[0]});
               if (exp_bus_q[0][8]) check_eq("bus_setup", 32'(stable_cnt >= SETUP), 1);
               void'(exp_bus_q.pop_front());
            end
            if (ack) viol_dav_ack <= viol_dav_ack + 1;
         end
         dav_hi_len <= dav ? dav_hi_len + 1 : 0;
         if (!dav && prev_dav) last_dav_len <= dav_hi_len;
      end
   end

   // ---------------------------------------------------------------------
   // Response scoreboard
   // ---------------------------------------------------------------------
   always @(negedge clock) begin
      if (_reset && host.rsp_valid) begin
         check_eq("rsp_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            check_eq("rsp", {21'd0, host.rsp_timeout, host.rsp_status, host.rsp_data},
                     {21'd0, exp_q[0]});
            void'(exp_q.pop_front());
         end
         if (ack) viol_rsp_ack <= viol_rsp_ack + 1;
      end
   end

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   function automatic void push_exp(input logic [1:0] op, input logic [7:0] d);
      exp_bus_q.push_back({1'b1, 8'(8'h81 + {6'd0, op})});
      if (op[1]) begin
         exp_bus_q.push_back(9'h000);
         exp_q.push_back({1'b0, status, resp_data});
      end else begin
         exp_bus_q.push_back({1'b1, d});
         exp_q.push_back({1'b0, status, 8'h00});
      end
   endfunction

   // Holds req_valid until n_acc requests were accepted; with scramble set,
   // req_data changes every clock so only the accepted value may be used.
   task automatic drive_req(input logic [1:0] op, input logic [7:0] d,
                            input int n_acc, input bit scramble);
      int acc   = 0;
      int guard = 0;
      @(negedge clock);
      host.req_valid = 1'b1;
      host.req_op    = op;
      host.req_data  = d;
      while (acc < n_acc && guard < 2000) begin
         if (host.req_ready) begin
            push_exp(op, host.req_data);
            acc++;
         end
         if (acc < n_acc) begin
            @(negedge clock);
            guard++;
            if (scramble) host.req_data = 8'($urandom_range(0, 255));
         end
      end
      check_eq("accepts", acc, n_acc);
      @(negedge clock);
      host.req_valid = 1'b0;
      if (scramble) host.req_data = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || exp_bus_q.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_eq(tag, 32'(exp_q.size() + exp_bus_q.size()), 0);
      exp_q.delete();
      exp_bus_q.delete();
      repeat (2) @(negedge clock);
      check_eq({tag, "_idle"}, 32'(dbg.state), 32'(IDLE));
   endtask

   // ---------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------
   int base_dav_ack, base_rsp_ack, n;

   initial begin
      host.req_valid = 1'b0;
      host.req_op    = 2'd0;
      host.req_data  = 8'h00;
      status         = 2'b00;

      repeat (3) @(negedge clock);
      check_eq("rst_dav",        32'(dav),              0);
      check_eq("rst_oe",         32'(dbg.port_oe),      0);
      check_eq("rst_state",      32'(dbg.state),        32'(IDLE));
      check_eq("rst_req_ready",  32'(host.req_ready),   1);
      check_eq("rst_rsp_valid",  32'(host.rsp_valid),   0);
      check_eq("rst_rsp_data",   32'(host.rsp_data),    0);
      check_eq("rst_rsp_status", 32'(host.rsp_status),  0);
      check_eq("rst_rsp_to",     32'(host.rsp_timeout), 0);
      _reset = 1'b1;

      // Send command byte: 0x81 then 0x4F
      status = 2'b00;
      drive_req(2'd0, 8'h4F, 1, 1'b0);
      wait_drain("t_send_cmd", 300);

      // Receive data: device returns 0xA5, status 01
      status = 2'b01; resp_data = 8'hA5;
      drive_req(2'd2, 8'h00, 1, 1'b0);
      wait_drain("t_recv_data", 300);

      // Receive status with ACK held high for 20 clocks
      status = 2'b10; resp_data = 8'h5A; ack_hold = 20;
      base_dav_ack = viol_dav_ack; base_rsp_ack = viol_rsp_ack;
      drive_req(2'd3, 8'h00, 1, 1'b0);
      wait_drain("t_recv_stat", 400);
      check_eq("dav_rise_while_ack", viol_dav_ack - base_dav_ack, 0);
      check_eq("rsp_while_ack",      viol_rsp_ack - base_rsp_ack, 0);
      ack_hold = 1;

      // Reset asserted while waiting for the data-byte ACK
      status = 2'b00; ack_delay = 40;
      drive_req(2'd0, 8'h3C, 1, 1'b0);
      n = 0;
      while (dbg.state != D_WAITHI && n < 300) begin
         @(negedge clock);
         n++;
      end
      check_eq("reach_d_waithi", 32'(dbg.state), 32'(D_WAITHI));
      _reset = 1'b0;
      #1;
      check_eq("mid_rst_dav",       32'(dav),            0);
      check_eq("mid_rst_oe",        32'(dbg.port_oe),    0);
      check_eq("mid_rst_req_ready", 32'(host.req_ready), 1);
      check_eq("mid_rst_state",     32'(dbg.state),      32'(IDLE));
      check_eq("mid_rst_rsp_valid", 32'(host.rsp_valid), 0);
      exp_q.delete();
      exp_bus_q.delete();
      @(negedge clock);
      _reset = 1'b1;
      ack_delay = 3;
      drive_req(2'd1, 8'h00, 1, 1'b0);
      wait_drain("t_after_rst", 300);

      // req_valid held across two transactions with changing req_data
      status = 2'b01;
      drive_req(2'd1, 8'hC3, 2, 1'b1);
      wait_drain("t_held_valid", 600);

      // Random ops, data, status and ACK delays
      for (int i = 0; i < 6; i++) begin
         status    = 2'($urandom_range(0, 3));
         resp_data = 8'($urandom_range(0, 255));
         ack_delay = $urandom_range(1, 6);
         drive_req(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1, 1'b0);
         wait_drain("t_random", 400);
      end
      ack_delay = 3;

`ifdef TCBM_TIMEOUT_EN
      // Silent responder: abort in C_WAITHI after TO_CYC clocks
      resp_silent = 1'b1;
      drive_req(2'd0, 8'h11, 1, 1'b0);
      void'(exp_bus_q.pop_back());
      void'(exp_q.pop_back());
      exp_q.push_back({1'b1, TCBM_TO_STATUS, 8'h00});
      wait_drain("t_timeout", 300);
      check_eq("timeout_dav_len", last_dav_len, TO_CYC);
      resp_silent = 1'b0;
      status = 2'b10;
      drive_req(2'd1, 8'h77, 1, 1'b0);
      wait_drain("t_after_timeout", 300);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tcbm_host_xfer.md
Name: tcbm_host_xfer

Overview:
Host-side TCBM initiator, the Plus/4 end of the link whose device end is the 1551 TPI port logic. It converts a single-word request into a two-byte TCBM transaction: a command code byte followed by a payload byte, either sent or received. The byte handshake is DAV (host to device) and ACK (device to host). It sits between the host CPU register interface and the 8-bit data, 2-bit status and DAV/ACK pins.

Parameters:
SETUP_CYCLES, 4, clocks that port_a is driven and stable before DAV rises (minimum 1).
TIMEOUT_CYCLES, 65535, clocks allowed in any ACK-wait state before abort (used only with TCBM_TIMEOUT_EN).
CNT_W, 16, width of the shared setup/timeout counter; must hold max(SETUP_CYCLES, TIMEOUT_CYCLES).

Ports:
clock  in  1  system clock
_reset  in  1  asynchronous active-low reset
req_valid  in  1  request strobe; accepted when req_valid && req_ready
req_op  in  2  0=send cmd (code 0x81), 1=send data (0x82), 2=recv data (0x83), 3=recv status (0x84)
req_data  in  8  payload byte for ops 0 and 1
req_ready  out  1  high only in IDLE
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  8  received byte (ops 2 and 3); 0x00 for sends
rsp_status  out  2  status pins latched with the payload byte
rsp_timeout  out  1  the transaction was aborted by timeout
port_a  inout  8  TCBM data bus
status  in  2  device status lines
dav  out  1  data valid, active-high
ack  in  1  device acknowledge, active-high

Behaviour:
- Reset, asynchronous with _reset low, including mid-transaction:
  - outputs: dav=0, port_a hi-Z, req_ready=1, rsp_valid=0, rsp_data=0x00, rsp_status=0, rsp_timeout=0.
  - internal: state=IDLE, counter=0, synchronizer=0.
- Synchronization: ack and status pass through a 2-flop synchronizer. All ACK decisions use the synchronized ack (acks).
- FSM states: IDLE, C_SETUP, C_WAITHI, C_WAITLO, D_SETUP, D_WAITHI, D_WAITLO, DONE.
- IDLE: on accept, latch op and data. Drive the code byte (0x81 + op) on port_a. Clear the counter. Go to C_SETUP.
- C_SETUP: count SETUP_CYCLES clocks, then set dav=1 and go to C_WAITHI.
- C_WAITHI: when acks=1, set dav=0 and go to C_WAITLO.
- C_WAITLO: when acks=0, go to D_SETUP.
  - Ops 0/1: drive the payload on port_a.
  - Ops 2/3: release port_a (hi-Z).
- D_SETUP: count SETUP_CYCLES clocks, then set dav=1 and go to D_WAITHI.
- D_WAITHI: when acks=1, set dav=0 and go to D_WAITLO.
  - Receive ops: latch rsp_data=port_a and rsp_status=status(sync) on the same edge.
  - Send ops: latch rsp_status only.
- D_WAITLO: when acks=0, release port_a and go to DONE.
- DONE: rsp_valid=1 for exactly one clock, then IDLE. req_ready returns the following clock.
- rsp_data and rsp_status hold until the next completion.
- Requests presented while req_ready=0 are ignored; there is no queue.
- ACK already high when entering a WAITHI state (stale ACK): no special case; the FSM proceeds on the level.
- Minimum transaction latency: 2*(SETUP_CYCLES+1) + 4*sync delay + 1 clocks.

Optional Feature:
TCBM_TIMEOUT_EN:
- Defined:
  - The counter clears on entry to each WAIT state and increments every clock while waiting.
  - On reaching TIMEOUT_CYCLES: dav=0, port_a hi-Z, rsp_timeout=1, rsp_data=0x00, rsp_status=2'b11, go to DONE.
  - rsp_timeout clears on the next accept.
- Undefined:
  - No timeout; WAIT states wait indefinitely.
  - rsp_timeout is tied 0.

Decomposition:
- Package tcbm_pkg:
  - op encodings;
  - code constants TCBM_CMD=0x81, TCBM_DOUT=0x82, TCBM_DIN=0x83, TCBM_STAT=0x84;
  - FSM state enum;
  - timeout status value 2'b11.
- One sub-module, tcbm_sync2: a 3-bit 2-flop synchronizer for {ack, status}, reset to 0 by _reset.

Test Plan:
- Op 0, data 0x4F, responder acks 3 clocks after each DAV rise → port_a shows 0x81 then 0x4F, each driven ≥4 clocks before DAV rises. rsp_valid pulses once, rsp_timeout=0.
- Op 2, responder drives 0xA5 with status=2'b01 before raising ACK → port_a hi-Z during the data phase, rsp_data=0xA5, rsp_status=2'b01.
- Op 3, status=2'b10, responder holds ACK high 20 clocks → DAV stays low while ACK is high. Completion comes only after ACK falls; rsp_status=2'b10.
- _reset asserted during D_WAITHI → immediately dav=0, port_a hi-Z, req_ready=1; a following op 1 with 0x00 completes normally.
- TCBM_TIMEOUT_EN with TIMEOUT_CYCLES=50 and a silent responder → timeout occurs in C_WAITHI. dav falls 50 clocks after rising; rsp_timeout=1, rsp_status=2'b11, rsp_data=0x00.
- req_valid held high across a transaction with a changing req_data → exactly one transaction per accept, and only the value latched at the accept is used.
